// File: rtl/alu_mul_sequencer.sv
// Shift-and-add unsigned multiplier that borrows the shared combinational ALU.
// One partial-product add per cycle in CALC; the low N bits of the product are
// published with a one-cycle Done pulse.
module alu_mul_sequencer #(
   parameter int unsigned N     = 64,
   parameter int unsigned CNT_W = 7
) (
   input  logic           CLK,
   input  logic           Reset,
   input  logic           Start,
   input  logic [N-1:0]   Multiplicand,
   input  logic [N-1:0]   Multiplier,
   output logic           Busy,
   output logic           Done,
   output logic [N-1:0]   Product,
   output logic [N-1:0]   ALU_BusA,
   output logic [N-1:0]   ALU_BusB,
   output logic [3:0]     ALU_Ctrl,
   input  logic [N-1:0]   ALU_BusW
);

   localparam logic [3:0]       AluAdd   = 4'b0010;
   localparam logic [3:0]       AluPassB = 4'b0111;
   localparam logic [CNT_W-1:0] LastCnt  = CNT_W'(N - 1);

   typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

   state_e           stateQ, stateD;
   logic [N-1:0]     accQ, accD;
   logic [N-1:0]     mQ, mD;
   logic [N-1:0]     qQ, qD;
   logic [N-1:0]     productQ, productD;
   logic [CNT_W-1:0] cntQ, cntD;
   logic             busyQ, doneQ;
   logic             lastIter;

   // Stop once no multiplier bits remain above the one consumed this cycle.
   assign lastIter = (qQ[N-1:1] == '0) || (cntQ == LastCnt);

   // Next-state, datapath updates and ALU port drive, decoded from registers only.
   always_comb begin
      stateD   = stateQ;
      accD     = accQ;
      mD       = mQ;
      qD       = qQ;
      cntD     = cntQ;
      productD = productQ;
      ALU_Ctrl = AluPassB;
      ALU_BusA = '0;
      ALU_BusB = '0;
      case (stateQ)
         StIdle: begin
            if (Start) begin
               mD     = Multiplicand;
               qD     = Multiplier;
               accD   = '0;
               cntD   = '0;
               stateD = StCalc;
            end
         end
         StCalc: begin
            ALU_Ctrl = AluAdd;
            ALU_BusA = accQ;
            ALU_BusB = qQ[0] ? mQ : '0;
            accD     = ALU_BusW;
            mD       = mQ << 1;
            qD       = qQ >> 1;
            cntD     = cntQ + 1'b1;
            if (lastIter) begin
               // Capture the final sum as it lands in acc.
               productD = ALU_BusW;
               stateD   = StDone;
            end
         end
         StDone: begin
            stateD = StIdle;
         end
         default: begin
            stateD = StIdle;
         end
      endcase
   end

   // State and datapath registers with synchronous reset; Busy/Done are flopped.
   always_ff @(posedge CLK) begin
      if (Reset) begin
         stateQ   <= StIdle;
         accQ     <= '0;
         mQ       <= '0;
         qQ       <= '0;
         cntQ     <= '0;
         productQ <= '0;
         busyQ    <= 1'b0;
         doneQ    <= 1'b0;
      end else begin
         stateQ   <= stateD;
         accQ     <= accD;
         mQ       <= mD;
         qQ       <= qD;
         cntQ     <= cntD;
         productQ <= productD;
         busyQ    <= (stateD == StCalc);
         doneQ    <= (stateD == StDone);
      end
   end

   assign Busy    = busyQ;
   assign Done    = doneQ;
   assign Product = productQ;

endmodule
